gate_truth_table_tester: RTL and testbench

Self-checking stimulus/response stage for two-input logic-gate modules such as the NAND gate block. It sits directly around the gate under test: upstream it drives the gate's A and B inputs through all four input combinations, and downstream it samples the gate's Y output. It compares each Y sample against a parameterised truth table and reports pass/fail plus a per-vector failure mask, so gate blocks can be checked in hardware as well as in simulation.

---
 rtl/logic_gate_pkg.sv | 11 +
 rtl/gate_truth_table_tester_if.sv | 21 ++
 rtl/gate_truth_table_tester_settle_counter.sv | 18 +
 rtl/gate_truth_table_tester.sv | 73 +++++++
 tb/tb_gate_truth_table_tester.sv | 101 ++++++++++
 5 files changed

// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared FSM states, vector count and gate truth tables
package logic_gate_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam int NUM_VECTORS = 4;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
endpackage

// File: rtl/gate_truth_table_tester_if.sv
// gate_truth_table_tester_if: stimulus/response bundle between tester and its user
interface gate_truth_table_tester_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] mismatch_count;
  logic [1:0] vector_idx;
  modport master (
    output start, y_in,
    input  a_out, b_out, busy, done, pass, fail_mask, mismatch_count, vector_idx
  );
  modport slave (
    input  start, y_in,
    output a_out, b_out, busy, done, pass, fail_mask, mismatch_count, vector_idx
  );
endinterface

// File: rtl/gate_truth_table_tester_settle_counter.sv
// settle_counter: counts hold cycles, flags the last one at SETTLE_CYCLES-1
module settle_counter #(
  parameter int SETTLE_CYCLES = 2,
  localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  // count while enabled, restart from zero on clear
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/gate_truth_table_tester.sv
// gate_truth_table_tester: sweeps A/B through 00..11 and checks Y against a truth table
module gate_truth_table_tester
  import logic_gate_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE = TT_NAND,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  gate_truth_table_tester_if.slave bus
);
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..255");
  end
  state_t state;
  logic tc;
  logic miss;
  logic [3:0] miss_bit;
  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk(clk),
    .rst(rst),
    .clear(state != DRIVE),
    .en(state == DRIVE),
    .tc(tc)
  );
  // X/Z on Y must count as a mismatch, hence case-inequality
  always_comb begin
    miss = bus.y_in !== TRUTH_TABLE[bus.vector_idx];
    miss_bit = miss ? 4'b0001 << bus.vector_idx : 4'b0000;
  end
  // sweep sequencer with registered stimulus and result outputs
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.a_out <= 1'b0;
      bus.b_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_mask <= '0;
      bus.mismatch_count <= '0;
      bus.vector_idx <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (bus.start) begin
            state <= DRIVE;
            {bus.a_out, bus.b_out} <= 2'b00;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.pass <= 1'b0;
            bus.fail_mask <= '0;
            bus.mismatch_count <= '0;
            bus.vector_idx <= '0;
          end
        DRIVE: if (tc) state <= SAMPLE;
        SAMPLE: begin
          bus.fail_mask <= bus.fail_mask | miss_bit;
          bus.mismatch_count <= bus.mismatch_count + 3'(miss);
          if (bus.vector_idx == 2'(NUM_VECTORS - 1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.fail_mask | miss_bit) == '0;
          end else begin
            state <= DRIVE;
            bus.vector_idx <= bus.vector_idx + 2'd1;
            {bus.a_out, bus.b_out} <= bus.vector_idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_gate_truth_table_tester.sv
// tb_gate_truth_table_tester: randomized sweeps checked against a truth-table model
module tb_gate_truth_table_tester;
  import logic_gate_pkg::*;
  localparam int S = 2;
  localparam int P = S + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aux_start = 1'b0;
  logic [3:0] gate_tt = TT_NAND;
  logic [2:0] p4 = 3'b111;
  logic [2:0] p1 = 3'b111;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  gate_truth_table_tester_if bus();
  gate_truth_table_tester_if bus4();
  gate_truth_table_tester_if bus1();
  assign bus.y_in = gate_tt[{bus.a_out, bus.b_out}];
  assign bus4.start = aux_start;
  assign bus1.start = aux_start;
  assign bus4.y_in = p4[2];
  assign bus1.y_in = p1[2];
  // NAND gates whose output lags the inputs by three cycles
  always @(posedge clk) begin
    p4 <= {p4[1:0], ~(bus4.a_out & bus4.b_out)};
    p1 <= {p1[1:0], ~(bus1.a_out & bus1.b_out)};
  end
  gate_truth_table_tester dut (.clk(clk), .rst(rst), .bus(bus));
  gate_truth_table_tester #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  gate_truth_table_tester #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input logic [3:0] tt);
    logic [3:0] em;
    int pc;
    gate_tt = tt;
    em = tt ^ TT_NAND;
    pc = $urandom_range(1, 4 * P - 1);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("restart_clear", {bus.done, bus.pass, bus.fail_mask, bus.mismatch_count}, 0);
    for (int c = 0; c < 4 * P; c++) begin
      check("vector", {bus.busy, bus.done, bus.vector_idx, bus.a_out, bus.b_out},
            {1'b1, 1'b0, 2'(c / P), 2'(c / P)});
      bus.start = c == pc;
      tick;
    end
    bus.start = 1'b0;
    check("done", {bus.busy, bus.done, bus.a_out, bus.b_out}, 4'b0111);
    check("fail_mask", bus.fail_mask, em);
    check("mismatch_count", bus.mismatch_count, $countones(em));
    check("pass", bus.pass, em == 4'b0000);
    repeat ($urandom_range(0, 3)) tick;
    check("hold", {bus.done, bus.pass, bus.fail_mask, bus.a_out, bus.b_out},
          {1'b1, em == 4'b0000, em, 2'b11});
  endtask
  initial begin
    bus.start = 1'b0;
    repeat (3) tick;
    check("reset", {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out,
                    bus.fail_mask, bus.mismatch_count, bus.vector_idx}, 0);
    rst = 1'b0;
    tick;
    sweep(TT_NAND);
    sweep(TT_AND);
    sweep(4'b1111);
    sweep(TT_XOR);
    for (int i = 0; i < 6; i++) sweep(4'($urandom));
    gate_tt = TT_AND;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (2 * P) tick;
    check("mid_idx", bus.vector_idx, 2);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_reset", {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out,
                        bus.fail_mask, bus.mismatch_count, bus.vector_idx}, 0);
    sweep(TT_NAND);
    aux_start = 1'b1;
    tick;
    aux_start = 1'b0;
    for (int i = 0; i < 200 && !(bus4.done && bus1.done); i++) tick;
    check("aux_done", {bus4.done, bus1.done}, 2'b11);
    check("settle4_pass", {bus4.pass, bus4.fail_mask}, {1'b1, 4'b0000});
    check("settle1_pass", {bus1.pass, bus1.fail_mask}, {1'b0, 4'b1000});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
